// File: rtl/rx_ds_pkg.sv
// rtl/rx_ds_pkg.sv - shared types, defaults and helpers for the rx phase downsampler
// Contents:
//   NBAUD_DEF, DW_DEF, WIN_LOG2_DEF : default parameter values
//   rx_ds_state_e                   : phase-selection state (MANUAL, ACQ, SEL, DONE)
//   abs_sat()                       : magnitude of a dw-bit two's complement value,
//                                     with the most negative code clamped to 2^(dw-1)-1
package rx_ds_pkg;

  localparam int NBAUD_DEF    = 4;
  localparam int DW_DEF       = 8;
  localparam int WIN_LOG2_DEF = 9;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    ACQ    = 2'd1,
    SEL    = 2'd2,
    DONE   = 2'd3
  } rx_ds_state_e;

  // x must already be sign-extended from dw bits; the result fits in dw-1 bits.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int dw);
    logic [31:0] lim;
    lim = (32'd1 << (dw - 1)) - 32'd1;
    if (!x[31]) return $unsigned(x);
    if (x == (-$signed(lim) - 32'sd1)) return lim;
    return $unsigned(-x);
  endfunction

endpackage

// File: rtl/rx_ds_energy_acc.sv
// rtl/rx_ds_energy_acc.sv - one saturating-magnitude energy accumulator
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear the accumulator (wins over add)
//   add      : add |sample| this cycle
//   sample   : two's complement sample, DW bits
//   acc      : running sum of magnitudes, AW bits
module rx_ds_energy_acc
  import rx_ds_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = DW_DEF - 1 + WIN_LOG2_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          add,
  input  logic [DW-1:0] sample,
  output logic [AW-1:0] acc
);

  logic [31:0] mag;
  logic        unused_mag_hi;

  assign mag = abs_sat(32'(signed'(sample)), DW);
  // Bits above DW-2 are always zero after saturation.
  assign unused_mag_hi = ^mag[31:DW-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + AW'(mag[DW-2:0]);
    end
  end

endmodule

// File: rtl/rx_phase_downsampler.sv
// rtl/rx_phase_downsampler.sv - selects one of NBAUD sampling phases and slices it to a hard bit
// Build option: RX_DS_AUTO_PHASE_EN enables max-energy automatic phase acquisition;
// without it the block is manual-only and i_auto is ignored.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_enable     : one strobe per oversampled sample
//   i_sample     : signed filter output (DW bits), valid with i_enable
//   i_auto       : 1 = automatic phase acquisition, 0 = manual phase
//   i_phase_man  : manual phase
//   o_bit        : sign of the selected sample (held between decisions)
//   o_bit_valid  : one-cycle strobe per decided bit
//   o_phase      : phase in use
//   o_locked     : o_phase is final
module rx_phase_downsampler
  import rx_ds_pkg::*;
#(
  parameter int NBAUD    = NBAUD_DEF,
  parameter int DW       = DW_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic [DW-1:0]            i_sample,
  input  logic                     i_auto,
  input  logic [$clog2(NBAUD)-1:0] i_phase_man,
  output logic                     o_bit,
  output logic                     o_bit_valid,
  output logic [$clog2(NBAUD)-1:0] o_phase,
  output logic                     o_locked
);

  localparam int PW = $clog2(NBAUD);

  logic [PW-1:0] pc;
  logic [PW-1:0] phase_q;
  logic          locked_q;
  logic          bit_q;
  logic          bit_valid_q;
  logic          phase_manual;
  logic [PW-1:0] use_phase;

  // Free-running phase counter; NBAUD is a power of two so it wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (i_enable) begin
      pc <= pc + PW'(1);
    end
  end

  // In manual mode the live i_phase_man is compared so a change applies to the next strobe.
  assign use_phase = phase_manual ? i_phase_man : phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      if (i_enable && locked_q && (pc == use_phase)) begin
        bit_q       <= i_sample[DW-1];
        bit_valid_q <= 1'b1;
      end
    end
  end

`ifdef RX_DS_AUTO_PHASE_EN
  localparam int AW = DW - 1 + WIN_LOG2;

  rx_ds_state_e        state, state_d;
  logic                auto_q;
  logic [WIN_LOG2-1:0] sym_cnt, sym_cnt_d;
  logic [PW-1:0]       scan, scan_d;
  logic [PW-1:0]       best_idx, best_idx_d;
  logic [AW-1:0]       best_val, best_val_d;
  logic [PW-1:0]       phase_d;
  logic                locked_d;
  logic                acc_clr;
  logic                add_en;
  logic [AW-1:0]       acc [NBAUD];

  for (genvar g = 0; g < NBAUD; g++) begin : g_acc
    rx_ds_energy_acc #(
      .DW (DW),
      .AW (AW)
    ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .add    (add_en && (pc == PW'(g))),
      .sample (i_sample),
      .acc    (acc[g])
    );
  end

  assign phase_manual = (state == MANUAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Starting directly in ACQ keeps the first post-reset sample in the window.
      state    <= i_auto ? ACQ : MANUAL;
      auto_q   <= i_auto;
      sym_cnt  <= '0;
      scan     <= '0;
      best_idx <= '0;
      best_val <= '0;
      phase_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_d;
      auto_q   <= i_auto;
      sym_cnt  <= sym_cnt_d;
      scan     <= scan_d;
      best_idx <= best_idx_d;
      best_val <= best_val_d;
      phase_q  <= phase_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d    = state;
    sym_cnt_d  = sym_cnt;
    scan_d     = scan;
    best_idx_d = best_idx;
    best_val_d = best_val;
    phase_d    = phase_q;
    locked_d   = locked_q;
    acc_clr    = 1'b0;
    add_en     = 1'b0;

    if (i_auto && !auto_q) begin
      state_d   = ACQ;
      acc_clr   = 1'b1;
      sym_cnt_d = '0;
      locked_d  = 1'b0;
    end else if (!i_auto && auto_q) begin
      state_d = MANUAL;
    end else begin
      case (state)
        MANUAL: begin
          phase_d  = i_phase_man;
          locked_d = 1'b1;
        end
        ACQ: begin
          locked_d = 1'b0;
          if (i_enable) begin
            add_en = 1'b1;
            if (pc == PW'(NBAUD - 1)) begin
              sym_cnt_d = sym_cnt + WIN_LOG2'(1);
              if (&sym_cnt) begin
                state_d    = SEL;
                scan_d     = '0;
                best_idx_d = '0;
                best_val_d = '0;
              end
            end
          end
        end
        SEL: begin
          // Strictly greater keeps the lowest index on ties; a zero start value
          // makes phase 0 the answer when every accumulator is empty.
          if (acc[scan] > best_val) begin
            best_val_d = acc[scan];
            best_idx_d = scan;
          end
          scan_d = scan + PW'(1);
          if (scan == PW'(NBAUD - 1)) begin
            state_d  = DONE;
            phase_d  = (acc[scan] > best_val) ? scan : best_idx;
            locked_d = 1'b1;
          end
        end
        DONE: begin
          locked_d = 1'b1;
        end
        default: begin
          state_d = MANUAL;
        end
      endcase
    end
  end
`else
  logic unused_in;

  assign phase_manual = 1'b1;
  assign unused_in    = i_auto ^ (^i_sample[DW-2:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      phase_q  <= i_phase_man;
      locked_q <= 1'b1;
    end
  end
`endif

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_phase     = phase_q;
  assign o_locked    = locked_q;

endmodule

// File: tb/tb_rx_phase_downsampler.sv
// tb/tb_rx_phase_downsampler.sv - randomized self-checking bench for rx_phase_downsampler
module tb_rx_phase_downsampler;

  localparam int NBAUD    = 4;
  localparam int DW       = 8;
  localparam int WIN_LOG2 = 9;
  localparam int PW       = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [DW-1:0] i_sample;
  logic          i_auto;
  logic [PW-1:0] i_phase_man;
  logic          o_bit;
  logic          o_bit_valid;
  logic [PW-1:0] o_phase;
  logic          o_locked;

  always #5 clk = ~clk;

  rx_phase_downsampler #(
    .NBAUD    (NBAUD),
    .DW       (DW),
    .WIN_LOG2 (WIN_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_sample    (i_sample),
    .i_auto      (i_auto),
    .i_phase_man (i_phase_man),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .o_phase     (o_phase),
    .o_locked    (o_locked)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int   m_pc;
  int   m_phase;
  int   m_sym;
  int   m_sel_left;
  int   m_acc [NBAUD];
  bit   m_locked;
  bit   m_manual;
  bit   m_acq;
  logic exp_bit;
  bit   alt;
  bit   auto_drv;
  int   man_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int abs_ref(input int v);
    if (v <= -(1 << (DW - 1))) return (1 << (DW - 1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int best_phase();
    int b = 0;
    for (int p = 1; p < NBAUD; p++) if (m_acc[p] > m_acc[b]) b = p;
    return b;
  endfunction

  function automatic int gen(input int kind);
    int sgn;
    sgn = ($urandom_range(1, 0) == 1) ? -1 : 1;
    case (kind)
      0: begin
        if (m_pc == 2) begin
          alt = !alt;
          return alt ? 50 : -50;
        end
        return 0;
      end
      1: return (m_pc == 3) ? sgn * 100 : sgn * 10;
      2: return sgn * 40;
      3: return (m_pc == 1) ? -128 : ((m_pc == 0) ? 126 : 0);
      4: return (m_pc == 1) ? 120 : 0;
      default: return int'($urandom_range(255)) - 128;
    endcase
  endfunction

  task automatic model_clear(input bit a);
    m_pc = 0; m_locked = 0; exp_bit = 1'b0; m_phase = 0; m_sym = 0; m_sel_left = 0;
    for (int p = 0; p < NBAUD; p++) m_acc[p] = 0;
`ifdef RX_DS_AUTO_PHASE_EN
    m_manual = !a; m_acq = a;
`else
    m_manual = 1'b1; m_acq = 1'b0;
    if (a) m_manual = 1'b1;
`endif
  endtask

  task automatic do_reset(input bit a);
    @(negedge clk);
    rst = 1'b1; i_enable = 1'b0; i_sample = '0; i_auto = a; auto_drv = a;
    @(posedge clk); #1;
    check_eq("rst_bit", o_bit, 0);
    check_eq("rst_bit_valid", o_bit_valid, 0);
    check_eq("rst_phase", o_phase, 0);
    check_eq("rst_locked", o_locked, 0);
    @(posedge clk); #1;
    model_clear(a);
  endtask

  task automatic step(input bit en, input int sval, input int man);
    logic [DW-1:0] s;
    bit exp_v;
    bit win_done;
    s = DW'(sval);
    @(negedge clk);
    rst = 1'b0; i_enable = en; i_sample = s; i_phase_man = PW'(man); i_auto = auto_drv;
    exp_v = en && m_locked && (m_pc == (m_manual ? man : m_phase));
    if (exp_v) exp_bit = s[DW-1];
    win_done = 1'b0;
    if (m_acq && en) begin
      m_acc[m_pc] += abs_ref(sval);
      if (m_pc == NBAUD - 1) begin
        m_sym++;
        if (m_sym == (1 << WIN_LOG2)) win_done = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (en) m_pc = (m_pc + 1) % NBAUD;
    if (m_manual) m_locked = 1'b1;
    else if (m_sel_left > 0) begin
      m_sel_left--;
      if (m_sel_left == 0) begin
        m_locked = 1'b1;
        m_phase  = best_phase();
      end
    end
    if (win_done) begin
      m_acq      = 1'b0;
      m_sel_left = NBAUD;
    end
    check_eq("bit_valid", o_bit_valid, exp_v);
    check_eq("bit", o_bit, exp_bit);
    check_eq("locked", o_locked, m_locked);
    if (m_manual) check_eq("phase_man", o_phase, man);
    else if (m_locked) check_eq("phase_auto", o_phase, m_phase);
  endtask

  task automatic idle(input bit a);
    @(negedge clk);
    rst = 1'b0; i_enable = 1'b0; i_auto = a; auto_drv = a;
    @(posedge clk); #1;
    check_eq("idle_valid", o_bit_valid, 0);
  endtask

  task automatic run_acq(input int kind, input int gap, input int exp_phase, input string tag);
    int n;
    n = 0;
    while (!m_locked && n < 20000) begin
      if (gap > 1 && (n % gap) != 0) step(1'b0, 0, 0);
      else step(1'b1, gen(kind), 0);
      n++;
    end
    check_eq({tag, "_locked"}, o_locked, 1);
    check_eq({tag, "_phase"}, o_phase, exp_phase);
    repeat (12) step(1'b1, gen(kind), 0);
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_sample = '0; i_auto = 1'b0; i_phase_man = '0;
    auto_drv = 1'b0; alt = 1'b0;
    model_clear(1'b0);

    do_reset(1'b0);
    repeat (48) step(1'b1, gen(0), 2);

    man_r = 1;
    for (int i = 0; i < 200; i++) begin
      if (i % 17 == 0) man_r = int'($urandom_range(NBAUD - 1));
      step($urandom_range(2) != 0, gen(5), man_r);
    end

`ifdef RX_DS_AUTO_PHASE_EN
    do_reset(1'b1); run_acq(1, 1, 3, "acq");
    do_reset(1'b1); run_acq(2, 1, 0, "tie");
    do_reset(1'b1); run_acq(3, 1, 1, "sat");
    do_reset(1'b1); run_acq(1, 3, 3, "gap");

    do_reset(1'b1);
    repeat (50 * NBAUD) step(1'b1, gen(4), 0);
    repeat (3) idle(1'b0);
    idle(1'b1);
    for (int p = 0; p < NBAUD; p++) m_acc[p] = 0;
    m_sym = 0; m_acq = 1'b1; m_manual = 1'b0; m_locked = 1'b0;
    check_eq("restart_unlocked", o_locked, 0);
    run_acq(2, 1, 0, "restart");
    do_reset(1'b1);
`else
    do_reset(1'b1);
    repeat (48) step(1'b1, gen(0), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
